fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the decode/execute boundary of the pipeline.
- Keeps its own shadow pipeline of destination tags, one entry per downstream stage up to FWD_DEPTH, so the decode stage does not need to supply later-stage tags.
- For each of NUM_SRC source operands it produces a bypass select: register file, stage k result, or immediate override.
- Raises a stall when a source depends on a load whose data is not yet available.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_hazard_unit_if.sv | 34 +++
 rtl/fwd_src_sel.sv | 44 ++++
 rtl/fwd_hazard_unit.sv | 116 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
//   tag_t    : one shadow-pipeline entry {vld, wb, ld, dst}
//   SEL_RF   : select code for "read the register file"
//   sel_imm  : select code for "immediate override" given a forwarding depth
//   sel_w    : width of one per-source select field given a forwarding depth
package fwd_pkg;

  // Tag dst is stored at a fixed maximum width so the struct is not parameterised.
  // Addresses are zero-extended into it; REG_AW must not exceed this.
  localparam int unsigned MaxRegAw = 16;

  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic                vld;
    logic                wb;
    logic                ld;
    logic [MaxRegAw-1:0] dst;
  } tag_t;

  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int unsigned sel_imm(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bus of the hazard unit.
//   master : decode stage (drives id_* and flush, receives stall and fwd_sel)
//   slave  : fwd_hazard_unit
// Source i occupies id_src_addr[i*REG_AW +: REG_AW] and fwd_sel[i*SEL_W +: SEL_W].
interface fwd_hazard_unit_if #(
  parameter int unsigned REG_AW    = 3,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2
);
  localparam int unsigned SEL_W = fwd_pkg::sel_w(FWD_DEPTH);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC-1:0]        id_imm_sel;
  logic [REG_AW-1:0]         id_dst_addr;
  logic                      id_wb;
  logic                      id_is_load;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_imm_sel, id_dst_addr, id_wb, id_is_load,
    output flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_imm_sel, id_dst_addr, id_wb, id_is_load,
    input  flush,
    output stall, fwd_sel
  );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-source priority matcher. Scans the shadow tags from stage 1 upward and
// picks the youngest producer of this source's register.
//   src_addr_i / src_used_i / imm_sel_i : one decode source operand
//   tags_i                              : tag pipeline, index 0 = stage 1
//   sel_o                               : 0 = RF, k = stage k, FWD_DEPTH+1 = immediate
//   hazard_o                            : winning producer is a load not yet forwardable
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [REG_AW-1:0]      src_addr_i,
  input  logic                   src_used_i,
  input  logic                   imm_sel_i,
  input  tag_t [FWD_DEPTH-1:0]   tags_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   hazard_o
);

  logic found;

  always_comb begin
    sel_o    = SEL_W'(SEL_RF);
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found && src_used_i && tags_i[k].vld && tags_i[k].wb &&
          tags_i[k].dst == MaxRegAw'(src_addr_i)) begin
        found    = 1'b1;
        sel_o    = SEL_W'(k + 1);
        // Only the youngest match decides; an older match never masks a young load.
        hazard_o = tags_i[k].ld && ((k + 1) < LOAD_STAGE);
      end
    end
    if (imm_sel_i) begin
      sel_o    = SEL_W'(sel_imm(FWD_DEPTH));
      hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the decode/execute boundary.
// Tracks destination tags of the next FWD_DEPTH stages internally and produces a
// bypass select per source plus a load-use stall.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fwd_hazard_unit_if.slave (decode inputs, flush, stall, fwd_sel)
//   stall_cnt, fwd_cnt : statistics counters, present only with FWD_HAZARD_STATS_EN
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FWD_HAZARD_STATS_EN
  fwd_hazard_unit_if.slave  bus,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`else
  fwd_hazard_unit_if.slave  bus
`endif
);

  localparam int unsigned SEL_W = sel_w(FWD_DEPTH);

  tag_t [FWD_DEPTH-1:0]     tag_q, tag_d;
  logic [NUM_SRC-1:0]       hazard;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     stall;

  // Shadow tag pipeline; a stalled decode enters stage 1 as a bubble.
  always_comb begin
    tag_d        = tag_q;
    tag_d[0].vld = bus.id_valid & ~stall;
    tag_d[0].wb  = bus.id_wb;
    tag_d[0].ld  = bus.id_is_load;
    tag_d[0].dst = MaxRegAw'(bus.id_dst_addr);
    for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    if (bus.flush) begin
      tag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SEL_W     (SEL_W)
    ) u_src_sel (
      .src_addr_i(bus.id_src_addr[i*REG_AW +: REG_AW]),
      .src_used_i(bus.id_src_used[i]),
      .imm_sel_i (bus.id_imm_sel[i]),
      .tags_i    (tag_q),
      .sel_o     (sel[i*SEL_W +: SEL_W]),
      .hazard_o  (hazard[i])
    );
  end

  assign stall       = bus.id_valid & (|hazard);
  assign bus.stall   = stall;
  assign bus.fwd_sel = sel;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel[i*SEL_W +: SEL_W] != SEL_W'(SEL_RF) &&
          sel[i*SEL_W +: SEL_W] != SEL_W'(sel_imm(FWD_DEPTH))) begin
        fwd_inc = fwd_inc + 32'd1;
      end
    end
    fwd_sum     = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc};
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.id_valid && !stall) begin
      fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  // Cleared by reset only; flush leaves the statistics intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance (2 sources, depth 2,
// load stage 2) and a wide instance (3 sources, depth 3, load stage 3).
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(3), .NUM_SRC(2), .FWD_DEPTH(2)) ifa ();
  fwd_hazard_unit_if #(.REG_AW(3), .NUM_SRC(3), .FWD_DEPTH(3)) ifb ();

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt;
  logic [31:0] snap;
`endif

  fwd_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_STAGE(2)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
`ifdef FWD_HAZARD_STATS_EN
    .bus      (ifa.slave),
    .stall_cnt(a_stall_cnt),
    .fwd_cnt  (a_fwd_cnt)
`else
    .bus      (ifa.slave)
`endif
  );

  fwd_hazard_unit #(.REG_AW(3), .NUM_SRC(3), .FWD_DEPTH(3), .LOAD_STAGE(3)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
`ifdef FWD_HAZARD_STATS_EN
    .bus      (ifb.slave),
    .stall_cnt(b_stall_cnt),
    .fwd_cnt  (b_fwd_cnt)
`else
    .bus      (ifb.slave)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic [1:0] imm,
                         input logic [2:0] dst, input logic wb, input logic ld);
    ifa.id_valid    = v;
    ifa.id_src_addr = {s1, s0};
    ifa.id_src_used = used;
    ifa.id_imm_sel  = imm;
    ifa.id_dst_addr = dst;
    ifa.id_wb       = wb;
    ifa.id_is_load  = ld;
  endtask

  task automatic idle_a();
    drive_a(1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive_a(1'b1, 3'd0, 3'd0, 2'b11, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall_a got=%0b exp=0", ifa.stall);
    end
    checks++;
    if (ifa.fwd_sel !== 4'b0000) begin
      failures++; $display("FAIL reset_sel_a got=%b exp=0000", ifa.fwd_sel);
    end
    checks++;
    if (ifb.stall !== 1'b0 || ifb.fwd_sel !== 9'd0) begin
      failures++; $display("FAIL reset_b got stall=%0b sel=%b exp 0/0", ifb.stall, ifb.fwd_sel);
    end
    drive_a(1'b1, 3'd0, 3'd0, 2'b11, 2'b01, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.fwd_sel !== 4'b0011) begin
      failures++; $display("FAIL reset_imm_sel got=%b exp=0011", ifa.fwd_sel);
    end
`ifdef FWD_HAZARD_STATS_EN
    checks++;
    if (a_stall_cnt !== 32'd0 || a_fwd_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", a_stall_cnt, a_fwd_cnt);
    end
`endif
    idle_a();
  endtask

  task automatic test_alu_fwd();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd3, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 3'd3, 3'd0, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.fwd_sel[1:0] !== 2'd1 || ifa.stall !== 1'b0) begin
      failures++; $display("FAIL alu_stage1 got sel=%0d stall=%0b exp 1/0",
                           ifa.fwd_sel[1:0], ifa.stall);
    end
    tick();
    checks++;
    if (ifa.fwd_sel[1:0] !== 2'd2 || ifa.stall !== 1'b0) begin
      failures++; $display("FAIL alu_stage2 got sel=%0d stall=%0b exp 2/0",
                           ifa.fwd_sel[1:0], ifa.stall);
    end
    idle_a();
  endtask

  task automatic test_load_use();
`ifdef FWD_HAZARD_STATS_EN
    snap = a_stall_cnt;
`endif
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd5, 1'b1, 1'b1);
    tick();
    // Invalid decode never stalls but still computes the select.
    drive_a(1'b0, 3'd0, 3'd5, 2'b10, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b0 || ifa.fwd_sel[3:2] !== 2'd1) begin
      failures++; $display("FAIL load_invalid got stall=%0b sel=%0d exp 0/1",
                           ifa.stall, ifa.fwd_sel[3:2]);
    end
    ifa.id_valid = 1'b1;
    #1;
    checks++;
    if (ifa.stall !== 1'b1) begin
      failures++; $display("FAIL load_use_stall got=%0b exp=1", ifa.stall);
    end
    tick();
    checks++;
    if (ifa.stall !== 1'b0 || ifa.fwd_sel[3:2] !== 2'd2) begin
      failures++; $display("FAIL load_use_release got stall=%0b sel=%0d exp 0/2",
                           ifa.stall, ifa.fwd_sel[3:2]);
    end
    tick();
    checks++;
    if (ifa.stall !== 1'b0) begin
      failures++; $display("FAIL load_use_once got=%0b exp=0", ifa.stall);
    end
    idle_a();
`ifdef FWD_HAZARD_STATS_EN
    checks++;
    if (a_stall_cnt !== snap + 32'd1) begin
      failures++; $display("FAIL stall_cnt got=%0d exp=%0d", a_stall_cnt, snap + 32'd1);
    end
`endif
  endtask

  task automatic test_priority();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd2, 1'b1, 1'b0);
    tick();
    tick();
    drive_a(1'b1, 3'd2, 3'd2, 2'b11, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.fwd_sel !== 4'b0101) begin
      failures++; $display("FAIL priority got=%b exp=0101", ifa.fwd_sel);
    end
    idle_a();
  endtask

  task automatic test_imm();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd4, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 3'd4, 3'd4, 2'b11, 2'b01, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.fwd_sel !== 4'b0111 || ifa.stall !== 1'b0) begin
      failures++; $display("FAIL imm_override got sel=%b stall=%0b exp 0111/0",
                           ifa.fwd_sel, ifa.stall);
    end
    idle_a();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd4, 1'b1, 1'b1);
    tick();
    drive_a(1'b1, 3'd4, 3'd0, 2'b01, 2'b01, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b0 || ifa.fwd_sel[1:0] !== 2'd3) begin
      failures++; $display("FAIL imm_load got stall=%0b sel=%0d exp 0/3",
                           ifa.stall, ifa.fwd_sel[1:0]);
    end
    ifa.id_imm_sel = 2'b00;
    #1;
    checks++;
    if (ifa.stall !== 1'b1) begin
      failures++; $display("FAIL imm_off_load got=%0b exp=1", ifa.stall);
    end
    idle_a();
  endtask

  task automatic test_flush();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd1, 1'b1, 1'b1);
    tick();
    drive_a(1'b1, 3'd1, 3'd0, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b1) begin
      failures++; $display("FAIL flush_pre_stall got=%0b exp=1", ifa.stall);
    end
    ifa.flush = 1'b1;
    tick();
    ifa.flush = 1'b0;
    #1;
    checks++;
    if (ifa.stall !== 1'b0 || ifa.fwd_sel !== 4'b0000) begin
      failures++; $display("FAIL flush_clear got stall=%0b sel=%b exp 0/0000",
                           ifa.stall, ifa.fwd_sel);
    end
    idle_a();
    drive_a(1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 3'd1, 1'b1, 1'b1);
    tick();
    drive_a(1'b1, 3'd1, 3'd0, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.stall !== 1'b1) begin
      failures++; $display("FAIL rst_pre_stall got=%0b exp=1", ifa.stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ifa.stall !== 1'b0 || ifa.fwd_sel !== 4'b0000) begin
      failures++; $display("FAIL rst_clear got stall=%0b sel=%b exp 0/0000",
                           ifa.stall, ifa.fwd_sel);
    end
    idle_a();
  endtask

  task automatic test_param();
    ifb.id_valid    = 1'b1;
    ifb.id_src_addr = 9'd0;
    ifb.id_src_used = 3'b000;
    ifb.id_imm_sel  = 3'b000;
    ifb.id_dst_addr = 3'd5;
    ifb.id_wb       = 1'b1;
    ifb.id_is_load  = 1'b1;
    tick();
    ifb.id_src_addr = {3'd5, 3'd0, 3'd0};
    ifb.id_src_used = 3'b100;
    ifb.id_dst_addr = 3'd0;
    ifb.id_wb       = 1'b0;
    ifb.id_is_load  = 1'b0;
    #1;
    checks++;
    if (ifb.stall !== 1'b1 || ifb.fwd_sel[8:6] !== 3'd1) begin
      failures++; $display("FAIL param_stall1 got stall=%0b sel=%0d exp 1/1",
                           ifb.stall, ifb.fwd_sel[8:6]);
    end
    tick();
    checks++;
    if (ifb.stall !== 1'b1 || ifb.fwd_sel[8:6] !== 3'd2) begin
      failures++; $display("FAIL param_stall2 got stall=%0b sel=%0d exp 1/2",
                           ifb.stall, ifb.fwd_sel[8:6]);
    end
    tick();
    checks++;
    if (ifb.stall !== 1'b0 || ifb.fwd_sel[8:6] !== 3'd3) begin
      failures++; $display("FAIL param_release got stall=%0b sel=%0d exp 0/3",
                           ifb.stall, ifb.fwd_sel[8:6]);
    end
    ifb.id_imm_sel = 3'b001;
    #1;
    checks++;
    if (ifb.fwd_sel !== {3'd3, 3'd0, 3'd4}) begin
      failures++; $display("FAIL param_imm got=%b exp=%b", ifb.fwd_sel, {3'd3, 3'd0, 3'd4});
    end
    ifb.id_valid   = 1'b0;
    ifb.id_imm_sel = 3'b000;
    tick();
  endtask

  initial begin
    drive_a(1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    ifa.flush       = 1'b0;
    ifb.id_valid    = 1'b0;
    ifb.id_src_addr = 9'd0;
    ifb.id_src_used = 3'b000;
    ifb.id_imm_sel  = 3'b000;
    ifb.id_dst_addr = 3'd0;
    ifb.id_wb       = 1'b0;
    ifb.id_is_load  = 1'b0;
    ifb.flush       = 1'b0;

    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_imm();
    test_param();
    test_flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
